// File: rtl/custom_master_slave_ctrl_pkg.sv
// custom_master_slave_ctrl_pkg: register indices and burst FSM state type
package custom_master_slave_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_BASE   = 3'd1;
    localparam logic [2:0] REG_CMD    = 3'd2;
    localparam logic [2:0] REG_LEN    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

endpackage

// File: rtl/custom_master_slave_ctrl_if.sv
// custom_master_slave_ctrl_if: slave write port plus read/write unit strobes; CUSTOM_MASTER_SLAVE_READBACK_EN adds the read port
interface custom_master_slave_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              slave_write;
    logic              slave_chipselect;
    logic [2:0]        slave_address;
    logic [DATA_W-1:0] slave_writedata;
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
    logic              slave_read;
    logic [DATA_W-1:0] slave_readdata;
`endif
    logic              rdwr_cntl;
    logic              n_action;
    logic              add_data_sel;
    logic [ADDR_W-1:0] rdwr_address;

    modport slave (
        input  slave_write, slave_chipselect, slave_address, slave_writedata,
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
        input  slave_read,
        output slave_readdata,
`endif
        output rdwr_cntl, n_action, add_data_sel, rdwr_address
    );

    modport master (
        output slave_write, slave_chipselect, slave_address, slave_writedata,
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
        output slave_read,
        input  slave_readdata,
`endif
        input  rdwr_cntl, n_action, add_data_sel, rdwr_address
    );

endinterface

// File: rtl/custom_master_slave_ctrl_burst_seq.sv
// cms_burst_seq: address/data phase sequencer with shadow direction, address and count; CUSTOM_MASTER_SLAVE_READBACK_EN exposes status
module cms_burst_seq
    import custom_master_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              dir_in,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [DATA_W-1:0] len_in,
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
    output logic              busy,
    output logic [DATA_W-1:0] remaining,
`endif
    output logic              rdwr_cntl,
    output logic              n_action,
    output logic              add_data_sel,
    output logic [ADDR_W-1:0] rdwr_address
);

    state_t            state, state_nx;
    logic              dir, dir_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [DATA_W-1:0] cnt, cnt_nx;

    // state and shadow registers; reset is active high despite the name
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= IDLE;
            dir   <= 1'b0;
            addr  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            dir   <= dir_nx;
            addr  <= addr_nx;
            cnt   <= cnt_nx;
        end
    end

    // start latches shadows from idle, abort drops to idle, data phase advances one word
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        addr_nx  = addr;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (start) begin
                state_nx = ADDR;
                dir_nx   = dir_in;
                addr_nx  = base_in;
                cnt_nx   = len_in;
            end
        end else if (abort) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == ADDR) begin
            state_nx = DATA;
        end else begin
            addr_nx  = addr + ADDR_W'(ADDR_STRIDE);
            cnt_nx   = cnt - DATA_W'(1);
            state_nx = (cnt == DATA_W'(1)) ? IDLE : ADDR;
        end
        n_action     = state == IDLE;
        add_data_sel = state == ADDR;
        rdwr_cntl    = (state != IDLE) && dir;
        rdwr_address = (state == IDLE) ? '0 : addr;
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
        busy         = state != IDLE;
        remaining    = cnt;
`endif
    end

endmodule

// File: rtl/custom_master_slave_ctrl.sv
// custom_master_slave_ctrl: register file driving a burst sequencer; CUSTOM_MASTER_SLAVE_READBACK_EN adds registered readback and STATUS
module custom_master_slave_ctrl
    import custom_master_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = 4
) (
    input logic                          clk,
    input logic                          reset_n,
    custom_master_slave_ctrl_if.slave    bus
);

`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
    localparam int CTRL_W = DATA_W;
`else
    localparam int CTRL_W = 1;
`endif

    logic              wr, start, abort;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] base_reg;

    assign wr    = bus.slave_write && bus.slave_chipselect;
    assign start = wr && (bus.slave_address == REG_LEN) && (|bus.slave_writedata);
    assign abort = wr && (bus.slave_address == REG_CMD) && bus.slave_writedata[0];

`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
    logic [DATA_W-1:0] len_reg, remaining;
    logic              busy;

    // LEN is only kept for readback; the sequencer takes the count straight from the write
    always_ff @(posedge clk) begin
        if (reset_n)
            len_reg <= '0;
        else if (wr && bus.slave_address == REG_LEN)
            len_reg <= bus.slave_writedata;
    end

    // registered readback: stored registers, STATUS = {remaining, busy}, everything else 0
    always_ff @(posedge clk) begin
        if (reset_n)
            bus.slave_readdata <= '0;
        else if (bus.slave_read && bus.slave_chipselect)
            bus.slave_readdata <= (bus.slave_address == REG_CTRL)   ? ctrl_reg :
                                  (bus.slave_address == REG_BASE)   ? base_reg :
                                  (bus.slave_address == REG_LEN)    ? len_reg  :
                                  (bus.slave_address == REG_STATUS) ? {remaining[DATA_W-2:0], busy} : '0;
    end
`endif

    // CTRL and BASE take every write, busy or not; the running burst works from its shadows
    always_ff @(posedge clk) begin
        if (reset_n) begin
            ctrl_reg <= '0;
            base_reg <= '0;
        end else if (wr) begin
            if (bus.slave_address == REG_CTRL) ctrl_reg <= bus.slave_writedata[CTRL_W-1:0];
            if (bus.slave_address == REG_BASE) base_reg <= bus.slave_writedata;
        end
    end

    cms_burst_seq #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_seq (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .dir_in       (ctrl_reg[0]),
        .base_in      (ADDR_W'(base_reg)),
        .len_in       (bus.slave_writedata),
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
        .busy         (busy),
        .remaining    (remaining),
`endif
        .rdwr_cntl    (bus.rdwr_cntl),
        .n_action     (bus.n_action),
        .add_data_sel (bus.add_data_sel),
        .rdwr_address (bus.rdwr_address)
    );

endmodule

// File: tb/tb_custom_master_slave_ctrl.sv
// tb_custom_master_slave_ctrl: scoreboard of expected per-cycle master outputs for each burst scenario
module tb_custom_master_slave_ctrl;

    typedef struct packed {
        logic        n_action;
        logic        ads;
        logic        cntl;
        logic [31:0] addr;
    } out_t;

    localparam out_t IDLE_OUT = '{1'b1, 1'b0, 1'b0, 32'h0};

    logic tb_clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    out_t sb[$];

    always #5 tb_clk = ~tb_clk;

    custom_master_slave_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    custom_master_slave_ctrl #(.DATA_W(32), .ADDR_W(32), .ADDR_STRIDE(4)) dut (
        .clk     (tb_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic out_t cur();
        return {bus.n_action, bus.add_data_sel, bus.rdwr_cntl, bus.rdwr_address};
    endfunction

    task automatic push_burst(input logic dir, input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            logic [31:0] a;
            a = base + 32'(4 * k);
            sb.push_back('{1'b0, 1'b1, dir, a});
            sb.push_back('{1'b0, 1'b0, dir, a});
        end
        sb.push_back(IDLE_OUT);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1);
        bus.slave_write      = 1'b1;
        bus.slave_chipselect = cs;
        bus.slave_address    = a;
        bus.slave_writedata  = d;
        @(negedge tb_clk);
        bus.slave_write      = 1'b0;
        bus.slave_chipselect = 1'b0;
    endtask

    task automatic test_reset();
        out_t o;
        reset_n = 1'b1;
        repeat (2) @(negedge tb_clk);
        o = cur();
        n_cmp++;
        if (o !== IDLE_OUT) begin
            n_bad++;
            $display("FAIL reset: got %h, want %h", o, IDLE_OUT);
        end
        reset_n = 1'b0;
        @(negedge tb_clk);
    endtask

    task automatic test_read_burst();
        out_t o, e;
        int   i = 0;
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd584);
        wr_reg(3'd2, 32'd0);
        push_burst(1'b0, 32'd584, 22);
        wr_reg(3'd3, 32'd22);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL read_burst cycle %0d: got %h, want %h", i, o, e);
            end
            i++;
            @(negedge tb_clk);
        end
    endtask

    task automatic test_write_wrap();
        out_t o, e;
        int   i = 0;
        wr_reg(3'd0, 32'd1);
        wr_reg(3'd1, 32'hFFFF_FFFC);
        push_burst(1'b1, 32'hFFFF_FFFC, 2);
        wr_reg(3'd3, 32'd2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL write_wrap cycle %0d: got %h, want %h", i, o, e);
            end
            i++;
            @(negedge tb_clk);
        end
    endtask

    task automatic test_ignored();
        out_t o, e;
        int   i = 0;
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd3, 32'd5, 1'b0);
        wr_reg(3'd0, 32'd0, 1'b0);
        wr_reg(3'd1, 32'd123, 1'b0);
        wr_reg(3'd5, 32'd7);
        repeat (3) sb.push_back(IDLE_OUT);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ignored_idle cycle %0d: got %h, want %h", i, o, e);
            end
            i++;
            @(negedge tb_clk);
        end
        i = 0;
        push_burst(1'b1, 32'hFFFF_FFFC, 1);
        wr_reg(3'd3, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ignored_regs cycle %0d: got %h, want %h", i, o, e);
            end
            i++;
            @(negedge tb_clk);
        end
    endtask

    task automatic test_abort();
        out_t o, e;
        int   i = 0;
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd584);
        push_burst(1'b0, 32'd584, 10);
        wr_reg(3'd3, 32'd10);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge tb_clk);
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL abort_busy cycle %0d: got %h, want %h", c, o, e);
            end
        end
        sb.delete();
        wr_reg(3'd2, 32'd1);
        o = cur();
        n_cmp++;
        if (o !== IDLE_OUT) begin
            n_bad++;
            $display("FAIL abort_idle: got %h, want %h", o, IDLE_OUT);
        end
        push_burst(1'b0, 32'd584, 1);
        wr_reg(3'd3, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL abort_restart cycle %0d: got %h, want %h", i, o, e);
            end
            i++;
            @(negedge tb_clk);
        end
    endtask

    task automatic test_busy_writes_reset();
        out_t o, e;
        int   i = 0;
        push_burst(1'b0, 32'd584, 3);
        wr_reg(3'd3, 32'd3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL busy_writes cycle %0d: got %h, want %h", i, o, e);
            end
            if (i == 0) wr_reg(3'd1, 32'd100);
            else if (i == 1) wr_reg(3'd0, 32'd1);
            else if (i == 2) wr_reg(3'd3, 32'd7);
            else @(negedge tb_clk);
            i++;
        end
        i = 0;
        push_burst(1'b1, 32'd100, 2);
        wr_reg(3'd3, 32'd2);
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge tb_clk);
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL new_regs cycle %0d: got %h, want %h", c, o, e);
            end
        end
        sb.delete();
        reset_n = 1'b1;
        @(negedge tb_clk);
        reset_n = 1'b0;
        o = cur();
        n_cmp++;
        if (o !== IDLE_OUT) begin
            n_bad++;
            $display("FAIL mid_reset: got %h, want %h", o, IDLE_OUT);
        end
        push_burst(1'b0, 32'd0, 1);
        wr_reg(3'd3, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = cur();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL regs_zero cycle %0d: got %h, want %h", i, o, e);
            end
            i++;
            @(negedge tb_clk);
        end
    endtask

    initial begin
        reset_n              = 1'b1;
        bus.slave_write      = 1'b0;
        bus.slave_chipselect = 1'b0;
        bus.slave_address    = 3'd0;
        bus.slave_writedata  = 32'd0;
`ifdef CUSTOM_MASTER_SLAVE_READBACK_EN
        bus.slave_read       = 1'b0;
`endif
        test_reset();
        test_read_burst();
        test_write_wrap();
        test_ignored();
        test_abort();
        test_busy_writes_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
